// File: rtl/button_router_pkg.sv
// Shared constants for the button router: level polarity, channel indices, counter sizing.
`default_nettype none

package button_router_pkg;

  localparam logic BTN_PRESSED  = 1'b1;
  localparam logic BTN_RELEASED = 1'b0;

  localparam int CH_PROC   = 0;
  localparam int CH_ACCESS = 1;
  localparam int CH_GAME   = 2;
  localparam int CH_SCORE  = 3;

  // Bits needed for a counter that runs 0 .. max_count-1.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// One button: 2-flop sync, debounce counter, stable level and press strobe.
// Optional auto-repeat compiled in with macro BUTTON_REPEAT_EN.
`default_nettype none

module button_debounce
  import button_router_pkg::*;
#(
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_fire
);

  localparam int               c_CNT_W    = cnt_width(DEBOUNCE_CYC);
  localparam logic             c_RAW_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYC - 1);

  logic               r_meta;
  logic               r_sync;
  logic               r_stable;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_synced;
  logic               w_differs;
  logic               w_flip;
  logic               w_press;

  assign w_synced  = r_sync ^ c_RAW_IDLE;
  assign w_differs = (w_synced != r_stable);
  assign w_flip    = w_differs && (r_cnt == c_CNT_LAST);
  // Strobe is combinational so the router can register it together with sel/ch_en.
  assign w_press   = w_flip && (w_synced == BTN_PRESSED);
  assign o_level   = r_stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta   <= c_RAW_IDLE;
      r_sync   <= c_RAW_IDLE;
      r_stable <= BTN_RELEASED;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (!w_differs || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_flip) begin
        r_stable <= w_synced;
      end
    end
  end

`ifdef BUTTON_REPEAT_EN
  localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_REP_W   = cnt_width(c_REP_MAX);

  logic [c_REP_W-1:0] r_rep_cnt;
  logic               r_rep_first;
  logic [c_REP_W-1:0] w_rep_last;
  logic               w_rep_fire;

  assign w_rep_last = r_rep_first ? c_REP_W'(REPEAT_DELAY - 1) : c_REP_W'(REPEAT_RATE - 1);
  assign w_rep_fire = r_stable && (r_rep_cnt == w_rep_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (!r_stable) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end

  assign o_fire = w_press | w_rep_fire;
`else
  // Repeat timing has no effect when auto-repeat is compiled out.
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_repeat_unused
  end

  assign o_fire = w_press;
`endif

endmodule

`default_nettype wire

// File: rtl/button_router.sv
// Debounces NUM_BTN buttons and routes press pulses to the channel chosen by sel.
// Auto-repeat is enabled by defining macro BUTTON_REPEAT_EN.
`default_nettype none

module button_router
  import button_router_pkg::*;
#(
  parameter  int NUM_BTN      = 3,
  parameter  int NUM_CH       = 4,
  parameter  int ACTIVE_LOW   = 1,
  parameter  int DEBOUNCE_CYC = 50000,
  parameter  int REPEAT_DELAY = 25000000,
  parameter  int REPEAT_RATE  = 5000000,
  localparam int SEL_W        = $clog2(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_BTN-1:0]        i_btn_raw,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic [NUM_CH-1:0]         i_ch_en,
  output logic [NUM_BTN-1:0]        o_btn_level,
  output logic [NUM_CH*NUM_BTN-1:0] o_btn_out,
  output logic                      o_sel_err
);

  logic [NUM_BTN-1:0]        w_fire;
  logic                      w_sel_bad;
  logic [NUM_CH*NUM_BTN-1:0] w_route;
  logic [NUM_CH*NUM_BTN-1:0] r_btn_out;
  logic                      r_sel_err;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    button_debounce #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (i_btn_raw[gi]),
      .o_level (o_btn_level[gi]),
      .o_fire  (w_fire[gi])
    );
  end

  // An out-of-range select only exists when NUM_CH is not a power of two.
  if ((1 << SEL_W) > NUM_CH) begin : g_sel_range
    assign w_sel_bad = (i_sel >= SEL_W'(NUM_CH));
  end else begin : g_sel_full
    assign w_sel_bad = 1'b0;
  end

  always_comb begin
    w_route = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!w_sel_bad && (i_sel == SEL_W'(c)) && i_ch_en[c]) begin
        w_route[c*NUM_BTN +: NUM_BTN] = w_fire;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_out <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_btn_out <= w_route;
      r_sel_err <= w_sel_bad;
    end
  end

  assign o_btn_out = r_btn_out;
  assign o_sel_err = r_sel_err;

endmodule

`default_nettype wire
